// File: rtl/synth_pkg.sv
// Shared synth voice definitions: envelope state encoding and common widths.
package synth_pkg;

  localparam int VOL_W  = 7;
  localparam int RATE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_state_t;

endpackage

// File: rtl/adsr_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, shared by envelope and LFO.
module adsr_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int                CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: registers use <= so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: gate/velocity in, 7-bit volume out, level stepped on a divided tick.
// Optional feature macro: ADSR_VELOCITY_EN (peak follows velocity instead of full scale).
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int LEVEL_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gate,
  input  logic [VOL_W-1:0]  velocity,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [VOL_W-1:0]  sustain_lvl,
  input  logic [RATE_W-1:0] release_rate,
  output logic [VOL_W-1:0]  volume,
  output logic              active
);

  localparam int SHIFT = LEVEL_W - VOL_W;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [LEVEL_W:0]   wide_t;

  adsr_state_t      state;
  level_t           level;
  logic             gate_q;
  logic [VOL_W-1:0] peak;
  logic [VOL_W-1:0] sus_vol;
  logic             tick;
  logic             rise;
  logic             fall;
  level_t           peak_lvl;
  level_t           sus_lvl;
  wide_t            att_sum;
  wide_t            dec_diff;
  wide_t            rel_diff;

  adsr_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
    end
  end

`ifdef ADSR_VELOCITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak <= '0;
    end else if (rise) begin
      peak <= velocity;
    end
  end
`else
  logic unused_velocity;

  assign peak            = '1;
  assign unused_velocity = ^velocity;
`endif

  // Targets are whole volume steps; extra LEVEL_W bit on the arithmetic catches carry/borrow.
  assign sus_vol  = (sustain_lvl < peak) ? sustain_lvl : peak;
  assign peak_lvl = level_t'(peak) << SHIFT;
  assign sus_lvl  = level_t'(sus_vol) << SHIFT;
  assign att_sum  = {1'b0, level} + wide_t'(attack_rate);
  assign dec_diff = {1'b0, level} - wide_t'(decay_rate);
  assign rel_diff = {1'b0, level} - wide_t'(release_rate);

  assign volume = level[LEVEL_W-1 -: VOL_W];

  // Gate edges take priority over the tick; rise keeps the current level for a click-free retrigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      level  <= '0;
      active <= 1'b0;
    end else if (rise) begin
      state  <= ATTACK;
      active <= 1'b1;
    end else if (fall) begin
      if (state inside {ATTACK, DECAY, SUSTAIN}) begin
        state <= RELEASE;
      end
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (attack_rate == '0 || att_sum >= {1'b0, peak_lvl}) begin
            level <= peak_lvl;
            state <= DECAY;
          end else begin
            level <= att_sum[LEVEL_W-1:0];
          end
        end
        DECAY: begin
          if (decay_rate == '0 || dec_diff[LEVEL_W] || dec_diff[LEVEL_W-1:0] <= sus_lvl) begin
            level <= sus_lvl;
            state <= SUSTAIN;
          end else begin
            level <= dec_diff[LEVEL_W-1:0];
          end
        end
        SUSTAIN: begin
          level <= sus_lvl;
        end
        RELEASE: begin
          if (release_rate == '0 || rel_diff[LEVEL_W] || rel_diff[LEVEL_W-1:0] == '0) begin
            level  <= '0;
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            level <= rel_diff[LEVEL_W-1:0];
          end
        end
        default: begin
          level  <= '0;
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope (TICK_DIV=4) against an integer ADSR reference model.
module tb_adsr_envelope;

  localparam int TICK_DIV = 4;
  localparam int LEVEL_W  = 16;
  localparam int SHIFT    = LEVEL_W - 7;

  localparam int M_IDLE = 0;
  localparam int M_ATT  = 1;
  localparam int M_DEC  = 2;
  localparam int M_SUS  = 3;
  localparam int M_REL  = 4;

`ifdef ADSR_VELOCITY_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       gate = 1'b0;
  logic [6:0] velocity = '0;
  logic [7:0] attack_rate = '0;
  logic [7:0] decay_rate = '0;
  logic [6:0] sustain_lvl = '0;
  logic [7:0] release_rate = '0;
  logic [6:0] volume;
  logic       active;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: level in LEVEL_W units as a plain integer, phase as a small int.
  int m_phase;
  int m_level;
  int m_peak;
  int m_cnt;
  bit m_gate_q;
  bit m_tick;

  always #5 clk = ~clk;

  adsr_envelope #(
    .TICK_DIV (TICK_DIV),
    .LEVEL_W  (LEVEL_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gate         (gate),
    .velocity     (velocity),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_lvl  (sustain_lvl),
    .release_rate (release_rate),
    .volume       (volume),
    .active       (active)
  );

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [6:0] exp_vol();
    return 7'(m_level >> SHIFT);
  endfunction

  function automatic logic exp_act();
    return m_phase != M_IDLE;
  endfunction

  task automatic model_reset();
    m_phase  = M_IDLE;
    m_level  = 0;
    m_peak   = VEL_EN ? 0 : 127;
    m_cnt    = 0;
    m_gate_q = 1'b0;
    m_tick   = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic step();
    bit rise;
    bit fall;
    int p;
    int s;
    @(posedge clk);
    rise   = gate && !m_gate_q;
    fall   = !gate && m_gate_q;
    m_tick = (m_cnt == TICK_DIV - 1);
    m_cnt  = (m_cnt + 1) % TICK_DIV;
    p      = m_peak << SHIFT;
    s      = imin(int'(sustain_lvl), m_peak) << SHIFT;
    if (rise) begin
      m_phase = M_ATT;
      if (VEL_EN) m_peak = int'(velocity);
    end else if (fall) begin
      if (m_phase inside {M_ATT, M_DEC, M_SUS}) m_phase = M_REL;
    end else if (m_tick) begin
      case (m_phase)
        M_ATT: begin
          m_level = (attack_rate == 0) ? p : imin(m_level + int'(attack_rate), p);
          if (m_level == p) m_phase = M_DEC;
        end
        M_DEC: begin
          m_level = (decay_rate == 0) ? s : imax(m_level - int'(decay_rate), s);
          if (m_level == s) m_phase = M_SUS;
        end
        M_SUS: m_level = s;
        M_REL: begin
          m_level = (release_rate == 0) ? 0 : imax(m_level - int'(release_rate), 0);
          if (m_level == 0) m_phase = M_IDLE;
        end
        default: m_level = 0;
      endcase
    end
    m_gate_q = gate;
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    gate        = 1'b1;
    velocity    = 7'd100;
    attack_rate = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (volume !== 7'd0) begin
      n_fails++;
      $display("FAIL reset_volume: got %0d, want 0", volume);
    end
    n_checks++;
    if (active !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_active: got %0b, want 0", active);
    end
    gate = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (12) begin
      step();
      n_checks++;
      if ({active, volume} !== {1'b0, 7'd0}) begin
        n_fails++;
        $display("FAIL idle_after_reset: got vol=%0d act=%0b, want vol=0 act=0", volume, active);
      end
    end
  endtask

  task automatic test_full_adsr();
    int ticks;
    bit done;
    velocity     = 7'd127;
    attack_rate  = 8'd255;
    decay_rate   = 8'd128;
    sustain_lvl  = 7'd64;
    release_rate = 8'd255;
    gate         = 1'b1;
    ticks        = 0;
    done         = 1'b0;
    for (int i = 0; i < 1400 && !done; i++) begin
      step();
      if (m_tick) ticks++;
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL adsr_attack t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
      if (volume == 7'd127) done = 1'b1;
    end
    n_checks++;
    if (!done || ticks > 257) begin
      n_fails++;
      $display("FAIL adsr_peak_time: reached=%0b after %0d ticks, want reached within 257", done, ticks);
    end
    done = 1'b0;
    for (int i = 0; i < 1400 && !done; i++) begin
      step();
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL adsr_decay t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
      if (volume == 7'd64) done = 1'b1;
    end
    repeat (80) step();
    n_checks++;
    if (volume !== 7'd64) begin
      n_fails++;
      $display("FAIL adsr_sustain_hold: got %0d, want 64", volume);
    end
    gate = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL adsr_release t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
      if (!active) done = 1'b1;
    end
    n_checks++;
    if (!done || volume !== 7'd0) begin
      n_fails++;
      $display("FAIL adsr_idle: got vol=%0d act=%0b, want vol=0 act=0", volume, active);
    end
  endtask

  task automatic test_instant_rates();
    int n;
    logic [6:0] want_peak;
    want_peak    = VEL_EN ? 7'd100 : 7'd127;
    velocity     = 7'd100;
    sustain_lvl  = 7'd50;
    attack_rate  = 8'd0;
    decay_rate   = 8'd0;
    release_rate = 8'd0;
    gate         = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (volume == 7'd0 && n < 12);
    n_checks++;
    if (volume !== want_peak || n > TICK_DIV + 1) begin
      n_fails++;
      $display("FAIL instant_attack: got vol=%0d after %0d clocks, want %0d within %0d",
               volume, n, want_peak, TICK_DIV + 1);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (volume == want_peak && n < 12);
    n_checks++;
    if (volume !== 7'd50 || n > TICK_DIV) begin
      n_fails++;
      $display("FAIL instant_decay: got vol=%0d after %0d clocks, want 50 within %0d", volume, n, TICK_DIV);
    end
    gate = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (active && n < 12);
    n_checks++;
    if ({active, volume} !== {1'b0, 7'd0} || n > TICK_DIV + 1) begin
      n_fails++;
      $display("FAIL instant_release: got vol=%0d act=%0b after %0d clocks, want vol=0 act=0",
               volume, active, n);
    end
  endtask

  task automatic test_retrigger();
    int v_ret;
    int min_v;
    bit done;
    velocity     = 7'd127;
    attack_rate  = 8'd255;
    decay_rate   = 8'd0;
    sustain_lvl  = 7'd127;
    release_rate = 8'd200;
    gate         = 1'b1;
    for (int i = 0; i < 1500 && m_phase != M_SUS; i++) step();
    gate = 1'b0;
    for (int i = 0; i < 1500 && exp_vol() > 7'd40; i++) begin
      step();
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL retrig_release t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
    end
    v_ret       = int'(exp_vol());
    velocity    = 7'd90;
    attack_rate = 8'd100;
    gate        = 1'b1;
    min_v       = 127;
    done        = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      min_v = imin(min_v, int'(volume));
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL retrig_attack t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
      if (m_phase == M_SUS) done = 1'b1;
    end
    n_checks++;
    if (v_ret < 30 || min_v < v_ret) begin
      n_fails++;
      $display("FAIL retrig_no_drop: got minimum vol=%0d, want at least %0d (near 40)", min_v, v_ret);
    end
    n_checks++;
    if (volume !== (VEL_EN ? 7'd90 : 7'd127)) begin
      n_fails++;
      $display("FAIL retrig_peak: got %0d, want %0d", volume, VEL_EN ? 90 : 127);
    end
  endtask

  task automatic test_sustain_clamp();
    release_rate = 8'd0;
    gate         = 1'b0;
    for (int i = 0; i < 12 && m_phase != M_IDLE; i++) step();
    velocity    = 7'd30;
    sustain_lvl = 7'd90;
    attack_rate = 8'd255;
    decay_rate  = 8'd255;
    gate        = 1'b1;
    for (int i = 0; i < 1500 && m_phase != M_SUS; i++) begin
      step();
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL clamp_approach t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
    end
    repeat (20) step();
    n_checks++;
    if (volume !== (VEL_EN ? 7'd30 : 7'd90)) begin
      n_fails++;
      $display("FAIL sustain_clamp: got %0d, want %0d", volume, VEL_EN ? 30 : 90);
    end
  endtask

  task automatic test_edge_collision();
    gate         = 1'b0;
    release_rate = 8'd0;
    attack_rate  = 8'd0;
    velocity     = 7'd110;
    for (int i = 0; i < 12 && m_phase != M_IDLE; i++) step();
    for (int i = 0; i < 8 && m_cnt != TICK_DIV - 1; i++) step();
    gate = 1'b1;
    step();
    n_checks++;
    if ({active, volume} !== {1'b1, 7'd0}) begin
      n_fails++;
      $display("FAIL collision_rise: got vol=%0d act=%0b, want vol=0 act=1", volume, active);
    end
    gate = 1'b0;
    step();
    n_checks++;
    if ({active, volume} !== {1'b1, 7'd0}) begin
      n_fails++;
      $display("FAIL pulse_release: got vol=%0d act=%0b, want vol=0 act=1", volume, active);
    end
    for (int i = 0; i < 8 && active; i++) step();
    n_checks++;
    if ({active, volume} !== {1'b0, 7'd0}) begin
      n_fails++;
      $display("FAIL pulse_idle: got vol=%0d act=%0b, want vol=0 act=0", volume, active);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int note = 0; note < 16; note++) begin
      velocity     = 7'($urandom_range(1, 127));
      attack_rate  = 8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255));
      decay_rate   = 8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255));
      release_rate = 8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255));
      sustain_lvl  = 7'($urandom_range(0, 127));
      gate         = ~gate;
      hold         = int'($urandom_range(2, 300));
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 99) == 0) sustain_lvl = 7'($urandom_range(0, 127));
        step();
        n_checks++;
        if ({active, volume} !== {exp_act(), exp_vol()}) begin
          n_fails++;
          $display("FAIL random note=%0d t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                   note, $time, volume, active, exp_vol(), exp_act());
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    velocity    = 7'd127;
    attack_rate = 8'd255;
    gate        = 1'b0;
    step();
    gate = 1'b1;
    repeat (60) step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({active, volume} !== {1'b0, 7'd0}) begin
      n_fails++;
      $display("FAIL mid_note_reset: got vol=%0d act=%0b, want vol=0 act=0", volume, active);
    end
    gate = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (8) begin
      step();
      n_checks++;
      if ({active, volume} !== {exp_act(), exp_vol()}) begin
        n_fails++;
        $display("FAIL post_reset t=%0t: got vol=%0d act=%0b, want vol=%0d act=%0b",
                 $time, volume, active, exp_vol(), exp_act());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_full_adsr();
    test_instant_rates();
    test_retrigger();
    test_sustain_clamp();
    test_edge_collision();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
